pwm_multi_channel: RTL and testbench
====================================

PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent PWM outputs (1..14).
REQ-002 SHALL have parameter WIDTH, default 8: counter/period/duty width in bits (2..32).
REQ-003 SHALL have parameter ADDR_W, default 4: register address width; CHANNELS+2 <= 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port address  input  ADDR_W  register select: 0=PERIOD, 1=CTRL, 2+i=DUTY[i].
REQ-007 SHALL have port write  input  1  write strobe, single-cycle, no wait states.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port byteenable  input  4  byte lane k qualifies writedata[8k+7:8k].
REQ-010 SHALL have port read  input  1  read strobe.
REQ-011 SHALL have port readdata  output  32  registered read data, valid the cycle after read.
REQ-012 SHALL have port pwm_out  output  CHANNELS  registered PWM outputs.
REQ-013 SHALL have port cycle_end  output  1  one-clock pulse on each reload cycle.

Function
REQ-014 SHALL keep shadow registers PERIOD[WIDTH-1:0], CTRL (bit0 run, bits[CHANNELS:1] channel enable, bit[CHANNELS+1] mode), DUTY[i][WIDTH-1:0]; only enabled lanes that overlap a register update it; writes to unmapped addresses SHALL be ignored.
REQ-015 SHALL return shadow values zero-extended on reads, 0 for unmapped addresses, readdata holding its value when read=0.
REQ-016 SHALL keep active copies of PERIOD and DUTY[i] that drive the counter and comparators; CTRL SHALL act immediately.
REQ-017 With run=0: counter SHALL hold 0, pwm_out SHALL be 0, cycle_end SHALL be 0, and every shadow write SHALL also load the active copy in the same cycle.
REQ-018 With run=1, mode=0 (edge): counter SHALL count 0..P-1 and wrap to 0, P=active PERIOD; reload cycle is counter==P-1.
REQ-019 On a reload cycle, active copies SHALL load from shadow and cycle_end SHALL assert for that one clock.
REQ-020 A write coinciding with a reload cycle SHALL update shadow only; the reload SHALL take the pre-write shadow value, the new value taking effect at the following boundary.
REQ-021 pwm_out[i] SHALL be registered as run & enable[i] & (counter < active DUTY[i]), one clock behind counter.
REQ-022 Boundaries: DUTY=0 -> constant low; DUTY>=P -> constant high; P=0 -> counter held 0, all outputs low, cycle_end never asserted; P=1 -> reload every cycle.
REQ-023 Clearing run mid-period SHALL zero counter and outputs on the next edge; setting run SHALL start at counter 0.

Reset
REQ-024 On reset low: all shadow and active registers, CTRL, counter, direction, readdata, pwm_out and cycle_end SHALL be 0, asynchronously.
REQ-025 After reset release, the first rising edge SHALL operate normally with run=0.

Configuration
REQ-026 Macro PWM_CENTER_ALIGN_EN defined: mode=1 SHALL count up 0..P-1 then down P-1..0 (each endpoint held one clock, period 2P clocks), reload on counter==0 while counting down, giving symmetric high time 2*DUTY.
REQ-027 Macro PWM_CENTER_ALIGN_EN undefined: the mode bit SHALL not be stored, SHALL read 0, and operation is edge-aligned only.

Verification
REQ-028 Reset, PERIOD=10, DUTY0=3, CTRL=0x03 -> pwm_out[0] high 3 clocks of every 10; cycle_end pulses every 10 clocks.
REQ-029 Running, write DUTY0=7 mid-period -> current period keeps 3-high; next period onward 7-high; readback DUTY0=7 immediately.
REQ-030 DUTY1=0, DUTY2=10, DUTY3=200 with PERIOD=10, all enabled -> ch1 always low, ch2 and ch3 always high.
REQ-031 Write PERIOD with byteenable=0b0000 -> PERIOD unchanged; write 0x1234 with byteenable=0b0001, WIDTH=8 -> PERIOD=0x34.
REQ-032 Assert reset mid-period with outputs high -> all outputs and readdata 0 immediately, without a clock edge.
REQ-033 With PWM_CENTER_ALIGN_EN, mode=1, PERIOD=8, DUTY0=2 -> ch0 high 4 clocks of every 16, centred on counter minimum; cycle_end every 16 clocks.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with shadowed PERIOD/DUTY registers reloaded at period boundaries.
// Define PWM_CENTER_ALIGN_EN to enable the center-aligned (up/down) counting mode bit.
module pwm_multi_channel #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic [3:0]          byteenable,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                cycle_end
);

    localparam int CW = CHANNELS + 2;
`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [CW-1:0] CTRL_MASK = '1;
`else
    localparam logic [CW-1:0] CTRL_MASK = {1'b0, {(CW-1){1'b1}}};
`endif

    logic [WIDTH-1:0]    period_sh, period_act, counter;
    logic [WIDTH-1:0]    duty_sh  [CHANNELS];
    logic [WIDTH-1:0]    duty_act [CHANNELS];
    logic [CW-1:0]       ctrl;
    logic                dir;

    logic [31:0]         lane_mask, read_value;
    logic [WIDTH-1:0]    period_new;
    logic [WIDTH-1:0]    duty_new [CHANNELS];
    logic [CW-1:0]       ctrl_new;
    logic                sel_period, sel_ctrl;
    logic [CHANNELS-1:0] sel_duty;
    logic                run, mode, active, last, reload;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [31:0] mask);
        return (old & ~mask) | (data & mask);
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            lane_mask[8*k +: 8] = {8{byteenable[k]}};
        end
        period_new = WIDTH'(merge(32'(period_sh), writedata, lane_mask));
        ctrl_new   = CW'(merge(32'(ctrl), writedata, lane_mask)) & CTRL_MASK;
        sel_period = write && (address == '0);
        sel_ctrl   = write && (address == ADDR_W'(1));
        read_value = '0;
        if (address == '0)
            read_value = 32'(period_sh);
        else if (address == ADDR_W'(1))
            read_value = 32'(ctrl);
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            duty_new[i] = WIDTH'(merge(32'(duty_sh[i]), writedata, lane_mask));
            sel_duty[i] = write && (address == ADDR_W'(i + 2));
            if (address == ADDR_W'(i + 2))
                read_value = 32'(duty_sh[i]);
        end
    end

    assign run = ctrl[0];
`ifdef PWM_CENTER_ALIGN_EN
    assign mode = ctrl[CW-1];
`else
    assign mode = 1'b0;
`endif
    assign active = run && (period_act != '0);
    assign last   = (counter == period_act - WIDTH'(1));
    // Center mode reloads at the bottom of the down-count; edge mode at the top.
    assign reload = active && (mode ? (dir && counter == '0) : last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_sh  <= '0;
            period_act <= '0;
            ctrl       <= '0;
            counter    <= '0;
            dir        <= 1'b0;
            readdata   <= '0;
            pwm_out    <= '0;
            cycle_end  <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            if (sel_period)
                period_sh <= period_new;
            if (sel_ctrl)
                ctrl <= ctrl_new;
            // Reload takes the pre-write shadow; while stopped, writes go straight through.
            if (reload)
                period_act <= period_sh;
            else if (!run && sel_period)
                period_act <= period_new;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (sel_duty[i])
                    duty_sh[i] <= duty_new[i];
                if (reload)
                    duty_act[i] <= duty_sh[i];
                else if (!run && sel_duty[i])
                    duty_act[i] <= duty_new[i];
                pwm_out[i] <= active && ctrl[i+1] && (counter < duty_act[i]);
            end

            if (!active) begin
                counter <= '0;
                dir     <= 1'b0;
            end else if (!mode) begin
                counter <= last ? '0 : counter + WIDTH'(1);
                dir     <= 1'b0;
            end else if (!dir) begin
                if (last)
                    dir <= 1'b1;
                else
                    counter <= counter + WIDTH'(1);
            end else begin
                if (counter == '0)
                    dir <= 1'b0;
                else
                    counter <= counter - WIDTH'(1);
            end

            cycle_end <= reload;
            if (read)
                readdata <= read_value;
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: register vector table, directed
// boundary sequences and randomized traffic against a cycle-level reference model.
module tb_pwm_multi_channel;

    logic        clk, reset, write, read, cycle_end;
    logic [3:0]  address, byteenable, pwm_out;
    logic [31:0] writedata, readdata;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 0;

    pwm_multi_channel #(.CHANNELS(4), .WIDTH(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .byteenable(byteenable), .read(read),
        .readdata(readdata), .pwm_out(pwm_out), .cycle_end(cycle_end)
    );

    initial clk = 0;
    always #5 clk = ~clk;

`ifdef PWM_CENTER_ALIGN_EN
    localparam logic [5:0]  M_CTRL_MASK = 6'h3F;
    localparam logic [31:0] CTRL_EXP    = 32'h3E;
`else
    localparam logic [5:0]  M_CTRL_MASK = 6'h1F;
    localparam logic [31:0] CTRL_EXP    = 32'h1E;
`endif

    // Reference model: shadow/active registers and position within the current period.
    logic [7:0]  m_period, a_period;
    logic [7:0]  m_duty [4];
    logic [7:0]  a_duty [4];
    logic [5:0]  m_ctrl;
    int          t;
    logic [3:0]  e_pwm;
    logic        e_ce;
    logic [31:0] e_rd;

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (a == 0) return {24'b0, m_period};
        if (a == 1) return {26'b0, m_ctrl};
        if (a >= 2 && a <= 5) return {24'b0, m_duty[a - 2]};
        return 32'b0;
    endfunction

    task automatic model_reset();
        m_period = 0; a_period = 0; m_ctrl = 0; t = 0;
        e_pwm = 0; e_ce = 0; e_rd = 0;
        for (int i = 0; i < 4; i++) begin m_duty[i] = 0; a_duty[i] = 0; end
    endtask

    task automatic model_step();
        logic        was_run, running;
        logic [31:0] merged;
        was_run = m_ctrl[0];
        running = was_run && (a_period != 0);
        for (int i = 0; i < 4; i++)
            e_pwm[i] = running && m_ctrl[i+1] && (t < int'(a_duty[i]));
        e_ce = running && (t == int'(a_period) - 1);
        if (read) e_rd = mread(address);
        if (e_ce) begin
            a_period = m_period;
            for (int i = 0; i < 4; i++) a_duty[i] = m_duty[i];
        end
        t = (running && !e_ce) ? t + 1 : 0;
        if (write) begin
            merged = lanes(mread(address), writedata, byteenable);
            if (address == 0) begin
                m_period = merged[7:0];
                if (!was_run) a_period = merged[7:0];
            end else if (address == 1) begin
                m_ctrl = merged[5:0] & M_CTRL_MASK;
            end else if (address >= 2 && address <= 5) begin
                m_duty[address - 2] = merged[7:0];
                if (!was_run) a_duty[address - 2] = merged[7:0];
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset(); else model_step();
        #1;
        if (chk_en) begin
            check("model_pwm", {28'b0, pwm_out}, {28'b0, e_pwm});
            check("model_cycle_end", {31'b0, cycle_end}, {31'b0, e_ce});
            check("model_readdata", readdata, e_rd);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        write = 1; address = a; writedata = d; byteenable = be;
        tick();
        write = 0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        read = 1; address = a;
        tick();
        read = 0;
        check(name, readdata, exp);
    endtask

    task automatic wait_ce();
        bit seen = 0;
        for (int n = 0; n < 64 && !seen; n++) begin
            tick();
            if (cycle_end) seen = 1;
        end
        if (!seen) begin
            tests++; failed++;
            $display("FAIL wait_cycle_end: got no pulse expected one within 64 clocks");
        end
    endtask

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int highs, ces, bad1, bad2, bad3, pat_bad;
        vecs[0]  = '{4'd0,  32'h0000000A, 4'hF, 4'd0,  32'h0A};
        vecs[1]  = '{4'd0,  32'h00000055, 4'h0, 4'd0,  32'h0A};
        vecs[2]  = '{4'd0,  32'h00001234, 4'h1, 4'd0,  32'h34};
        vecs[3]  = '{4'd0,  32'h000099FF, 4'h2, 4'd0,  32'h34};
        vecs[4]  = '{4'd2,  32'hFFFFFF03, 4'hF, 4'd2,  32'h03};
        vecs[5]  = '{4'd5,  32'h000000C8, 4'hF, 4'd5,  32'hC8};
        vecs[6]  = '{4'd6,  32'h00000077, 4'hF, 4'd6,  32'h00};
        vecs[7]  = '{4'd15, 32'h00000077, 4'hF, 4'd15, 32'h00};
        vecs[8]  = '{4'd1,  32'h0000FFFE, 4'h3, 4'd1,  CTRL_EXP};
        vecs[9]  = '{4'd1,  32'h0000001E, 4'h2, 4'd1,  CTRL_EXP};
        vecs[10] = '{4'd3,  32'hAB000000, 4'h8, 4'd3,  32'h00};

        reset = 0; write = 0; read = 0; address = 0; writedata = 0; byteenable = 0;
        repeat (3) tick();
        check("reset_pwm", {28'b0, pwm_out}, 32'h0);
        check("reset_cycle_end", {31'b0, cycle_end}, 32'h0);
        check("reset_readdata", readdata, 32'h0);
        #2 reset = 1;
        chk_en = 1;
        rd_check("reset_period", 4'd0, 32'h0);

        // Register map, byte lanes, unmapped addresses
        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata, vecs[i].be);
            rd_check($sformatf("table%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        address = 0;
        tick();
        check("readdata_hold", readdata, 32'h0);

        // Basic edge-aligned run: PERIOD=10, DUTY0=3
        wr(4'd1, 32'h0, 4'hF);
        wr(4'd0, 32'd10, 4'hF);
        wr(4'd2, 32'd3, 4'hF);
        wr(4'd1, 32'h03, 4'hF);
        highs = 0; ces = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            highs += int'(pwm_out[0]);
            ces   += int'(cycle_end);
        end
        check("basic_high_count", highs, 6);
        check("basic_cycle_end_count", ces, 2);

        // Mid-period duty change only takes effect at the next boundary
        wait_ce();
        highs = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            highs += int'(pwm_out[0]);
            if (j == 0) begin
                write = 1; address = 4'd2; writedata = 32'd7; byteenable = 4'hF;
            end else if (j == 1) begin
                write = 0; read = 1;
            end else if (j == 2) begin
                read = 0;
                check("duty_readback", readdata, 32'd7);
            end
        end
        check("old_duty_period", highs, 3);
        check("boundary_pulse", {31'b0, cycle_end}, 32'h1);
        highs = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            highs += int'(pwm_out[0]);
        end
        check("new_duty_period", highs, 7);

        // DUTY boundaries: 0, ==P, >P
        wr(4'd1, 32'h0, 4'hF);
        wr(4'd0, 32'd10, 4'hF);
        wr(4'd3, 32'd0, 4'hF);
        wr(4'd4, 32'd10, 4'hF);
        wr(4'd5, 32'd200, 4'hF);
        wr(4'd1, 32'h1F, 4'hF);
        tick();
        bad1 = 0; bad2 = 0; bad3 = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            bad1 += int'(pwm_out[1] != 1'b0);
            bad2 += int'(pwm_out[2] != 1'b1);
            bad3 += int'(pwm_out[3] != 1'b1);
        end
        check("duty0_always_low", bad1, 0);
        check("duty_eq_p_always_high", bad2, 0);
        check("duty_gt_p_always_high", bad3, 0);

        // Clearing run zeroes outputs on the following edge
        wr(4'd1, 32'h0, 4'hF);
        tick();
        check("run_clear_pwm", {28'b0, pwm_out}, 32'h0);

        // P=1 reloads every cycle
        wr(4'd0, 32'd1, 4'hF);
        wr(4'd2, 32'd1, 4'hF);
        wr(4'd1, 32'h03, 4'hF);
        tick();
        highs = 0; ces = 0;
        for (int j = 0; j < 6; j++) begin
            tick();
            highs += int'(pwm_out[0]);
            ces   += int'(cycle_end);
        end
        check("p1_cycle_end_count", ces, 6);
        check("p1_high_count", highs, 6);

        // P=0 stays idle
        wr(4'd1, 32'h0, 4'hF);
        wr(4'd0, 32'd0, 4'hF);
        wr(4'd1, 32'h1F, 4'hF);
        highs = 0; ces = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            highs += int'(pwm_out != 4'b0);
            ces   += int'(cycle_end);
        end
        check("p0_cycle_end_count", ces, 0);
        check("p0_active_outputs", highs, 0);

        // Asynchronous reset between clock edges
        wr(4'd1, 32'h0, 4'hF);
        wr(4'd0, 32'd10, 4'hF);
        wr(4'd4, 32'd10, 4'hF);
        wr(4'd1, 32'h1F, 4'hF);
        tick();
        rd_check("pre_reset_period", 4'd0, 32'd10);
        check("pre_reset_ch2_high", {31'b0, pwm_out[2]}, 32'h1);
        #3 reset = 0;
        model_reset();
        #1;
        check("async_reset_pwm", {28'b0, pwm_out}, 32'h0);
        check("async_reset_readdata", readdata, 32'h0);
        check("async_reset_cycle_end", {31'b0, cycle_end}, 32'h0);
        #2 reset = 1;

        // Randomized register traffic against the model
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] d;
            write   = ($urandom_range(0, 3) == 0);
            read    = ($urandom_range(0, 1) == 1);
            address = 4'($urandom_range(0, 7));
            byteenable = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            d = $urandom & 32'hFFFF_FF00;
            if (address == 1) d = d | 32'($urandom_range(0, 31));
            else              d = d | 32'($urandom_range(0, 14));
            writedata = d;
            tick();
        end
        write = 0; read = 0;
        tick();

`ifdef PWM_CENTER_ALIGN_EN
        // Center-aligned: PERIOD=8, DUTY0=2 -> 4 high of 16, centred on counter 0
        chk_en = 0;
        wr(4'd1, 32'h0, 4'hF);
        wr(4'd0, 32'd8, 4'hF);
        wr(4'd2, 32'd2, 4'hF);
        wr(4'd1, 32'h23, 4'hF);
        wait_ce();
        pat_bad = 0; highs = 0; ces = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            pat_bad += int'(pwm_out[0] != (j < 2 || j >= 14));
            pat_bad += int'(cycle_end != (j == 15));
            highs   += int'(pwm_out[0]);
            ces     += int'(cycle_end);
        end
        check("center_pattern", pat_bad, 0);
        check("center_high_count", highs, 4);
        check("center_cycle_end_count", ces, 1);
`else
        pat_bad = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
